// File: rtl/spike_log_pkg.sv
// Package for the spike event logger.
// Shared sizing constants and event-word layout for the logger and its FIFO.
//   N_SPK   : number of spike channels
//   TS_W    : timestamp counter width (free-running, wraps)
//   DEPTH   : FIFO entries (power of two >= 2)
//   EVT_W   : event word width {ts, spikes}
//   TS_LSB  : bit offset of the timestamp field inside an event word
//   SPK_LSB : bit offset of the spike-vector field inside an event word
//   CNT_W   : occupancy counter width (0..DEPTH inclusive)
package spike_log_pkg;

  localparam int N_SPK   = 3;
  localparam int TS_W    = 5;
  localparam int DEPTH   = 8;
  localparam int EVT_W   = TS_W + N_SPK;
  localparam int TS_LSB  = N_SPK;
  localparam int SPK_LSB = 0;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  // Build an event word; keeps the field order in one place.
  function automatic logic [EVT_W-1:0] pack_event(input logic [TS_W-1:0]  ts,
                                                   input logic [N_SPK-1:0] spk);
    logic [EVT_W-1:0] w;
    w = '0;
    w[TS_LSB  +: TS_W]  = ts;
    w[SPK_LSB +: N_SPK] = spk;
    return w;
  endfunction

endpackage

// File: rtl/spike_log_fifo.sv
// Show-ahead synchronous FIFO.
// The head entry is always presented on rdata while valid=1; rdata is a
// register that is updated with the next head at each edge, so it holds its
// last value while the FIFO is empty and reads 0 out of reset.
// Handshake: a push is accepted when the FIFO is not full, or when it is full
// and a pop happens in the same cycle; a pop is honoured only when valid=1.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data
//   pop        : advance head (ignored while empty)
//   rdata      : head entry
//   valid      : FIFO non-empty
//   count      : occupancy 0..ENTRIES
//   full       : count == ENTRIES
module spike_log_fifo #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(ENTRIES):0]   count,
  output logic                       full
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(ENTRIES));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Next head: if the slot about to become head is the one being written
    // this cycle (FIFO empty or draining its last entry), forward wdata.
    rdata_d = rdata_q;
    if (count_d != '0) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[rd_ptr_d];
      end
    end

    valid = ~empty;
    rdata = rdata_q;
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// Spike event logger.
// Records one event word {timestamp, spike vector} per cycle in which any
// spike is active (and capture is enabled) into a show-ahead FIFO that the
// host drains via rd_req/rd_valid/rd_data.
// Handshake: rd_valid=1 means rd_data holds the head entry; rd_req pops it at
// the clock edge only when rd_valid=1, otherwise rd_req is ignored.
// Optional feature macro: SPIKE_LOG_COUNT_EN enables per-channel 8-bit
// saturating spike counters on spk_cnt; without it spk_cnt is tied to 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : capture events when 1 (timestamp always runs)
//   spikes_in  : spike vector, bit i = neuron i fired
//   rd_req     : pop head entry
//   rd_valid   : FIFO non-empty
//   rd_data    : head entry {ts, spikes}
//   count      : FIFO occupancy 0..DEPTH
//   overflow   : sticky, an event was dropped because the FIFO was full
//   ovf_clr    : clear overflow (a drop in the same cycle keeps it set);
//                with counters enabled, a pop with ovf_clr=1 zeroes them
//   spk_cnt    : per-channel counters, channel i at [8i+7:8i]
module spike_event_logger
  import spike_log_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_SPK-1:0]   spikes_in,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [EVT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic [8*N_SPK-1:0] spk_cnt
);

  logic [TS_W-1:0] ts_q, ts_d;
  logic            overflow_q, overflow_d;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            drop;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    push       = enable & (|spikes_in);
    pop        = rd_req & rd_valid;
    // A full FIFO can still take an event if the head leaves this cycle.
    drop       = push & fifo_full & ~pop;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    overflow   = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
    end
  end

  spike_log_fifo #(
    .WIDTH   (EVT_W),
    .ENTRIES (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (pack_event(ts_q, spikes_in)),
    .pop   (rd_req),
    .rdata (rd_data),
    .valid (rd_valid),
    .count (count),
    .full  (fifo_full)
  );

`ifdef SPIKE_LOG_COUNT_EN
  logic [7:0] cnt_q [N_SPK];
  logic [7:0] cnt_d [N_SPK];

  always_comb begin
    spk_cnt = '0;
    for (int i = 0; i < N_SPK; i++) begin
      cnt_d[i] = cnt_q[i];
      // Counters see every enabled spike, accepted by the FIFO or not.
      if (pop && ovf_clr) begin
        cnt_d[i] = 8'd0;
      end else if (enable && spikes_in[i] && (cnt_q[i] != 8'hff)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
      spk_cnt[8*i +: 8] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SPK; i++) begin
      if (reset) begin
        cnt_q[i] <= 8'd0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign spk_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;
  import spike_log_pkg::*;

  // ---------------- clock / reset block ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [N_SPK-1:0]   spikes_in = '0;
  logic               rd_req = 1'b0;
  logic               ovf_clr = 1'b0;
  logic               rd_valid;
  logic [EVT_W-1:0]   rd_data;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [8*N_SPK-1:0] spk_cnt;

  always #5 clk = ~clk;

  spike_event_logger dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .spikes_in (spikes_in),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .spk_cnt   (spk_cnt)
  );

  // ---------------- reference model ----------------
  logic [EVT_W-1:0] exp_q[$];
  int               ts_m;
  logic             ovf_m;
  int               cnt_m [N_SPK];
  logic             was_reset;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event semantics from the behavioural rules: time-ordered queue bounded
  // by DEPTH, a pop frees room for a same-cycle event.
  task automatic model_step(input logic r, input logic e, input logic [N_SPK-1:0] s,
                            input logic rq, input logic clr);
    bit popped;
    bit dropped;
    if (r) begin
      exp_q.delete();
      ts_m  = 0;
      ovf_m = 1'b0;
      for (int i = 0; i < N_SPK; i++) cnt_m[i] = 0;
      was_reset = 1'b1;
      return;
    end
    was_reset = 1'b0;
    popped  = rq && (exp_q.size() > 0);
    dropped = 1'b0;
    if (popped) void'(exp_q.pop_front());
    if (e && (s != 0)) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(EVT_W'(ts_m * (1 << N_SPK) + int'(s)));
      else dropped = 1'b1;
    end
    if (dropped) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    for (int i = 0; i < N_SPK; i++) begin
      if (popped && clr) cnt_m[i] = 0;
      else if (e && s[i] && cnt_m[i] < 255) cnt_m[i]++;
    end
    ts_m = (ts_m + 1) % (1 << TS_W);
  endtask

  task automatic check_all();
    logic [8*N_SPK-1:0] exp_cnt;
    exp_cnt = '0;
`ifdef SPIKE_LOG_COUNT_EN
    for (int i = 0; i < N_SPK; i++) exp_cnt[8*i +: 8] = 8'(cnt_m[i]);
`endif
    check("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
    check("count",    32'(count),    32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("spk_cnt",  32'(spk_cnt),  32'(exp_cnt));
    if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
    if (was_reset)        check("rd_data_reset", 32'(rd_data), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are checked 1 ns after the
  // rising edge against the model advanced by the same inputs.
  task automatic cycle(input logic r, input logic e, input logic [N_SPK-1:0] s,
                       input logic rq, input logic clr);
    reset = r; enable = e; spikes_in = s; rd_req = rq; ovf_clr = clr;
    @(posedge clk);
    model_step(r, e, s, rq, clr);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    @(negedge clk);

    // 1: single event at ts=4, visible one cycle later.
    do_reset();
    idle(4);
    cycle(1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
    check("t1_data",  32'(rd_data),  32'({5'd4, 3'b101}));
    check("t1_count", 32'(count),    32'd1);
    check("t1_valid", 32'(rd_valid), 32'd1);
    idle(1);

    // 2: fill, one dropped event, drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 3'((i % 7) + 1), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
    check("t2_count_full", 32'(count),    32'(DEPTH));
    check("t2_overflow",   32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);
    check("t2_empty", 32'(rd_valid), 32'd0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: full FIFO, push and pop together.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
    check("t3_count",    32'(count),    32'(DEPTH));
    check("t3_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);
    check("t3_last", 32'(rd_data[SPK_LSB +: N_SPK]), 32'(3'b100));
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);

    // 4: timestamp wrap.
    do_reset();
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 1'b1, (i == 30 || i == 33) ? 3'b011 : 3'b000, 1'b0, 1'b0);
    check("t4_ts0", 32'(rd_data[TS_LSB +: TS_W]), 32'd30);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);
    check("t4_ts1", 32'(rd_data[TS_LSB +: TS_W]), 32'd1);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);

    // 5: capture disabled, read while empty.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
    check("t5_count", 32'(count), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t5_valid", 32'(rd_valid), 32'd0);

    // 6: counter saturation and clear-on-pop.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
`ifdef SPIKE_LOG_COUNT_EN
    check("t6_sat", 32'(spk_cnt), 32'd255);
`else
    check("t6_tied", 32'(spk_cnt), 32'd0);
`endif
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);
    check("t6_clear", 32'(spk_cnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom),
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
